// File: rtl/sram_bus_pkg.sv
// Shared SRAM bus definitions: widths, byte-enable encodings and default slow-window constants.
package sram_bus_pkg;

  localparam int unsigned SRAM_ADDR_W = 18;
  localparam int unsigned SRAM_DATA_W = 16;
  localparam int unsigned BUSY_CNT_W  = 4;

  // Active-low byte enables: bit 1 selects data[15:8], bit 0 selects data[7:0]
  localparam logic [1:0] BE_WORD = 2'b00;
  localparam logic [1:0] BE_HI   = 2'b01;
  localparam logic [1:0] BE_LO   = 2'b10;
  localparam logic [1:0] BE_NONE = 2'b11;

  localparam int unsigned            WAIT_CYCLES_DEFAULT = 3;
  localparam logic [SRAM_ADDR_W-1:0] SLOW_MASK_DEFAULT   = 18'h3C000;
  localparam logic [SRAM_ADDR_W-1:0] SLOW_BASE_DEFAULT   = 18'h30000;

  function automatic logic is_slow(input logic [SRAM_ADDR_W-1:0] adr,
                                   input logic [SRAM_ADDR_W-1:0] mask,
                                   input logic [SRAM_ADDR_W-1:0] base);
    return (adr & mask) == base;
  endfunction

endpackage

// File: rtl/sram_responder_if.sv
// External SRAM bus between xmemctrl (master) and the memory-side responder (slave).
interface sram_responder_if;
  import sram_bus_pkg::*;

  logic [SRAM_ADDR_W-1:0] SRAM_ADR;
  logic                   addr_strobe;
  logic                   SRAM_CE;
  logic                   SRAM_WE;
  logic                   SRAM_OE;
  logic [1:0]             SRAM_BE;
  logic [SRAM_DATA_W-1:0] SRAM_DAT_wr;
  logic                   SRAM_DAT_drive;
  logic [SRAM_DATA_W-1:0] SRAM_DAT_rd;
  logic                   use_memory_busy;
  logic                   memory_busy;
  logic                   bus_error;

  modport master (
    output SRAM_ADR, addr_strobe, SRAM_CE, SRAM_WE, SRAM_OE, SRAM_BE,
           SRAM_DAT_wr, SRAM_DAT_drive,
    input  SRAM_DAT_rd, use_memory_busy, memory_busy, bus_error
  );

  modport slave (
    input  SRAM_ADR, addr_strobe, SRAM_CE, SRAM_WE, SRAM_OE, SRAM_BE,
           SRAM_DAT_wr, SRAM_DAT_drive,
    output SRAM_DAT_rd, use_memory_busy, memory_busy, bus_error
  );

endinterface

// File: rtl/sram_wait_gen.sv
// Slow-window address decode and wait-state counter driving memory_busy.
module sram_wait_gen
  import sram_bus_pkg::*;
#(
  parameter int unsigned            WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter logic [SRAM_ADDR_W-1:0] SLOW_MASK   = SLOW_MASK_DEFAULT,
  parameter logic [SRAM_ADDR_W-1:0] SLOW_BASE   = SLOW_BASE_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [SRAM_ADDR_W-1:0] sram_adr,
  input  logic                   addr_strobe,
  output logic                   use_memory_busy,
  output logic                   memory_busy
);

  localparam logic [BUSY_CNT_W-1:0] WAIT_LOAD = BUSY_CNT_W'(WAIT_CYCLES);

  logic [BUSY_CNT_W-1:0] busy_cnt;
  logic [BUSY_CNT_W-1:0] busy_cnt_nxt_c;

  assign use_memory_busy = is_slow(sram_adr, SLOW_MASK, SLOW_BASE);

  // A strobe restarts the count (no accumulation); otherwise count down to zero
  always_comb begin
    busy_cnt_nxt_c = busy_cnt;
    if (addr_strobe) begin
      busy_cnt_nxt_c = use_memory_busy ? WAIT_LOAD : '0;
    end else if (busy_cnt != '0) begin
      busy_cnt_nxt_c = busy_cnt - BUSY_CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      busy_cnt    <= '0;
      memory_busy <= 1'b0;
    end else begin
      busy_cnt    <= busy_cnt_nxt_c;
      memory_busy <= (busy_cnt_nxt_c != '0);
    end
  end

endmodule

// File: rtl/sram_responder.sv
// 16-bit asynchronous SRAM emulation with slow-window wait states.
// Optional protocol checker enabled by defining SRAM_PROTOCOL_CHECK_EN.
module sram_responder
  import sram_bus_pkg::*;
#(
  parameter int unsigned            ADDR_W      = 12,
  parameter int unsigned            WAIT_CYCLES = WAIT_CYCLES_DEFAULT,
  parameter logic [SRAM_ADDR_W-1:0] SLOW_MASK   = SLOW_MASK_DEFAULT,
  parameter logic [SRAM_ADDR_W-1:0] SLOW_BASE   = SLOW_BASE_DEFAULT
) (
  input  logic               clock,
  input  logic               reset,
  sram_responder_if.slave    bus
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [SRAM_DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]      idx_c;
  logic                   rd_en_c;
  logic                   wr_commit_c;

  sram_wait_gen #(
    .WAIT_CYCLES (WAIT_CYCLES),
    .SLOW_MASK   (SLOW_MASK),
    .SLOW_BASE   (SLOW_BASE)
  ) u_wait_gen (
    .clock           (clock),
    .reset           (reset),
    .sram_adr        (bus.SRAM_ADR),
    .addr_strobe     (bus.addr_strobe),
    .use_memory_busy (bus.use_memory_busy),
    .memory_busy     (bus.memory_busy)
  );

  // Upper address bits alias onto the implemented array
  assign idx_c       = bus.SRAM_ADR[ADDR_W-1:0];
  assign rd_en_c     = !bus.SRAM_CE && !bus.SRAM_OE;
  assign wr_commit_c = !bus.SRAM_CE && !bus.SRAM_WE && bus.SRAM_DAT_drive && !bus.memory_busy;

  // Zero-latency read; a same-cycle write shows the old word until the edge
  assign bus.SRAM_DAT_rd = rd_en_c ? mem[idx_c] : '1;

  // Array is never cleared; reset only blocks a commit on its edge
  always_ff @(posedge clock) begin
    if (!reset && wr_commit_c) begin
      if (!bus.SRAM_BE[1]) mem[idx_c][15:8] <= bus.SRAM_DAT_wr[15:8];
      if (!bus.SRAM_BE[0]) mem[idx_c][7:0]  <= bus.SRAM_DAT_wr[7:0];
    end
  end

`ifdef SRAM_PROTOCOL_CHECK_EN
  logic violation_c;

  always_comb begin
    violation_c = 1'b0;
    if (!bus.SRAM_CE && !bus.SRAM_WE && !bus.SRAM_OE)        violation_c = 1'b1;
    if (!bus.SRAM_CE && !bus.SRAM_WE && !bus.SRAM_DAT_drive) violation_c = 1'b1;
    // Address moved while a write was stalled on wait states
    if (bus.addr_strobe && bus.memory_busy && !bus.SRAM_WE)  violation_c = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      bus.bus_error <= 1'b0;
    end else if (violation_c) begin
      bus.bus_error <= 1'b1;
    end
  end
`else
  assign bus.bus_error = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Scoreboard bench for sram_responder: stimulus queues expectations, a negedge monitor checks them.
module tb_sram_responder;
  import sram_bus_pkg::*;

  localparam int SIG_RD    = 0;
  localparam int SIG_UBUSY = 1;
  localparam int SIG_BUSY  = 2;
  localparam int SIG_ERR   = 3;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  logic clock;
  logic reset;
  int   n_tests;
  int   n_fail;
  exp_t sb_q[$];

  sram_responder_if bus();

  sram_responder dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Monitor: compare every queued expectation against the settled outputs
  always @(negedge clock) begin
    while (sb_q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = sb_q.pop_front();
      case (e.sig)
        SIG_RD:    act = bus.SRAM_DAT_rd;
        SIG_UBUSY: act = {15'd0, bus.use_memory_busy};
        SIG_BUSY:  act = {15'd0, bus.memory_busy};
        default:   act = {15'd0, bus.bus_error};
      endcase
      n_tests = n_tests + 1;
      if (act !== e.exp) begin
        n_fail = n_fail + 1;
        $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end
  end

  task automatic chk(input string name, input int sig, input logic [15:0] exp);
    exp_t e;
    e.name = name;
    e.sig  = sig;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  // Immediate check of a single-bit output at the next negedge
  task automatic now_chk(input string name, input int sig, input logic exp);
    logic act;
    @(negedge clock);
    #1;
    case (sig)
      SIG_UBUSY: act = bus.use_memory_busy;
      SIG_BUSY:  act = bus.memory_busy;
      default:   act = bus.bus_error;
    endcase
    n_tests = n_tests + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic cyc(input logic rst, input logic [17:0] adr, input logic stb,
                     input logic ce, input logic we, input logic oe,
                     input logic [1:0] be, input logic [15:0] dat, input logic drv);
    @(posedge clock);
    #1;
    reset              = rst;
    bus.SRAM_ADR       = adr;
    bus.addr_strobe    = stb;
    bus.SRAM_CE        = ce;
    bus.SRAM_WE        = we;
    bus.SRAM_OE        = oe;
    bus.SRAM_BE        = be;
    bus.SRAM_DAT_wr    = dat;
    bus.SRAM_DAT_drive = drv;
  endtask

  task automatic idle(input logic [17:0] adr);
    cyc(1'b0, adr, 1'b0, 1'b1, 1'b1, 1'b1, BE_NONE, 16'h0000, 1'b0);
  endtask

  task automatic write_fast(input logic [17:0] adr, input logic [15:0] dat, input logic [1:0] be);
    cyc(1'b0, adr, 1'b1, 1'b0, 1'b0, 1'b1, be, dat, 1'b1);
    chk("write_busy", SIG_BUSY, 16'h0);
  endtask

  task automatic read_chk(input logic [17:0] adr, input logic [15:0] exp, input string name);
    cyc(1'b0, adr, 1'b1, 1'b0, 1'b1, 1'b0, BE_WORD, 16'h0000, 1'b0);
    chk(name, SIG_RD, exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset              = 1'b1;
    bus.SRAM_ADR       = '0;
    bus.addr_strobe    = 1'b0;
    bus.SRAM_CE        = 1'b1;
    bus.SRAM_WE        = 1'b1;
    bus.SRAM_OE        = 1'b1;
    bus.SRAM_BE        = BE_NONE;
    bus.SRAM_DAT_wr    = '0;
    bus.SRAM_DAT_drive = 1'b0;

    cyc(1'b1, 18'h0, 1'b0, 1'b1, 1'b1, 1'b1, BE_NONE, 16'h0, 1'b0);
    cyc(1'b1, 18'h0, 1'b0, 1'b1, 1'b1, 1'b1, BE_NONE, 16'h0, 1'b0);
    idle(18'h0);
    chk("reset_busy", SIG_BUSY, 16'h0);
    chk("reset_err", SIG_ERR, 16'h0);
    chk("idle_rd", SIG_RD, 16'hFFFF);
    chk("reset_ubusy", SIG_UBUSY, 16'h0);
    now_chk("reset_busy_direct", SIG_BUSY, 1'b0);
    now_chk("reset_err_direct", SIG_ERR, 1'b0);

    // Word write/read in the fast window
    write_fast(18'h00010, 16'hA55A, BE_WORD);
    read_chk(18'h00010, 16'hA55A, "word_rd");
    chk("word_ubusy", SIG_UBUSY, 16'h0);
    chk("word_busy", SIG_BUSY, 16'h0);

    // Byte lanes
    write_fast(18'h00020, 16'h1234, BE_WORD);
    write_fast(18'h00020, 16'hABAB, BE_HI);
    read_chk(18'h00020, 16'hAB34, "be_hi_rd");
    write_fast(18'h00020, 16'hCDCD, BE_LO);
    read_chk(18'h00020, 16'hABCD, "be_lo_rd");
    write_fast(18'h00020, 16'h9999, BE_NONE);
    read_chk(18'h00020, 16'hABCD, "be_none_rd");

    // Slow read: busy for three cycles after the strobe; slow address aliases index 4
    write_fast(18'h00004, 16'h4444, BE_WORD);
    cyc(1'b0, 18'h30004, 1'b1, 1'b0, 1'b1, 1'b0, BE_WORD, 16'h0, 1'b0);
    chk("slow_ubusy", SIG_UBUSY, 16'h1);
    chk("slow_busy_t0", SIG_BUSY, 16'h0);
    chk("slow_alias_rd", SIG_RD, 16'h4444);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 18'h30004, 1'b0, 1'b0, 1'b1, 1'b0, BE_WORD, 16'h0, 1'b0);
      chk($sformatf("slow_busy_t%0d", i), SIG_BUSY, (i <= 3) ? 16'h1 : 16'h0);
    end
    now_chk("slow_wait_expired", SIG_BUSY, 1'b0);
    idle(18'h30004);
    chk("ubusy_ignores_ce", SIG_UBUSY, 16'h1);

    // Stalled write abandoned before busy clears: nothing may commit
    write_fast(18'h00008, 16'h1111, BE_WORD);
    cyc(1'b0, 18'h30008, 1'b1, 1'b0, 1'b1, 1'b1, BE_WORD, 16'h0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      cyc(1'b0, 18'h30008, 1'b0, 1'b0, 1'b0, 1'b1, BE_WORD, 16'hDEAD, 1'b1);
      chk("stall_busy", SIG_BUSY, 16'h1);
    end
    idle(18'h30008);
    read_chk(18'h00008, 16'h1111, "stall_holdoff_rd");

    // Stalled write held until busy clears: commits once busy drops
    cyc(1'b0, 18'h30008, 1'b1, 1'b0, 1'b1, 1'b1, BE_WORD, 16'h0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      cyc(1'b0, 18'h30008, 1'b0, 1'b0, 1'b0, 1'b1, BE_WORD, 16'h0F0F, 1'b1);
      chk($sformatf("stall2_busy_t%0d", i), SIG_BUSY, (i <= 3) ? 16'h1 : 16'h0);
    end
    idle(18'h30008);
    read_chk(18'h00008, 16'h0F0F, "stall_commit_rd");

    // Restart on a second slow strobe, then a fast strobe cancels busy
    cyc(1'b0, 18'h30010, 1'b1, 1'b0, 1'b1, 1'b1, BE_WORD, 16'h0, 1'b0);
    idle(18'h30010);
    chk("restart_busy_t1", SIG_BUSY, 16'h1);
    cyc(1'b0, 18'h30010, 1'b1, 1'b0, 1'b1, 1'b1, BE_WORD, 16'h0, 1'b0);
    for (int i = 3; i <= 6; i++) begin
      idle(18'h30010);
      chk($sformatf("restart_busy_t%0d", i), SIG_BUSY, (i <= 5) ? 16'h1 : 16'h0);
    end
    cyc(1'b0, 18'h30010, 1'b1, 1'b0, 1'b1, 1'b1, BE_WORD, 16'h0, 1'b0);
    cyc(1'b0, 18'h00010, 1'b1, 1'b0, 1'b1, 1'b1, BE_WORD, 16'h0, 1'b0);
    chk("fast_strobe_busy_before", SIG_BUSY, 16'h1);
    idle(18'h00010);
    chk("fast_strobe_clears", SIG_BUSY, 16'h0);

    // Pipelined zero-latency reads
    write_fast(18'h00000, 16'h0000, BE_WORD);
    write_fast(18'h00001, 16'h1111, BE_WORD);
    write_fast(18'h00002, 16'h2222, BE_WORD);
    write_fast(18'h00003, 16'h3333, BE_WORD);
    for (int i = 0; i < 4; i++) begin
      logic [15:0] pv;
      pv = {4{4'(i)}};
      read_chk(18'(i), pv, $sformatf("pipe_rd_%0d", i));
    end
    idle(18'h00003);
    chk("pipe_idle_rd", SIG_RD, 16'hFFFF);
    cyc(1'b0, 18'h00003, 1'b1, 1'b0, 1'b1, 1'b1, BE_WORD, 16'h0, 1'b0);
    chk("oe_high_rd", SIG_RD, 16'hFFFF);

    // Read-before-write in one cycle (a protocol violation when checking is on)
    cyc(1'b0, 18'h00020, 1'b1, 1'b0, 1'b0, 1'b0, BE_WORD, 16'h5555, 1'b1);
    chk("rbw_old_rd", SIG_RD, 16'hABCD);
    chk("rbw_err_before", SIG_ERR, 16'h0);
    read_chk(18'h00020, 16'h5555, "rbw_new_rd");
`ifdef SRAM_PROTOCOL_CHECK_EN
    chk("err_set", SIG_ERR, 16'h1);
    idle(18'h00020);
    idle(18'h00020);
    chk("err_sticky", SIG_ERR, 16'h1);
`else
    chk("err_tied_low", SIG_ERR, 16'h0);
    idle(18'h00020);
    idle(18'h00020);
    chk("err_stays_low", SIG_ERR, 16'h0);
`endif

    // Reset mid-access: busy clears
    cyc(1'b0, 18'h30000, 1'b1, 1'b0, 1'b1, 1'b1, BE_WORD, 16'h0, 1'b0);
    cyc(1'b1, 18'h30000, 1'b0, 1'b1, 1'b1, 1'b1, BE_NONE, 16'h0, 1'b0);
    chk("pre_reset_busy", SIG_BUSY, 16'h1);
    idle(18'h30000);
    chk("post_reset_busy", SIG_BUSY, 16'h0);
    chk("post_reset_err", SIG_ERR, 16'h0);

    // Write on the reset edge is suppressed; array survives reset
    cyc(1'b1, 18'h00010, 1'b0, 1'b0, 1'b0, 1'b1, BE_WORD, 16'h0000, 1'b1);
    idle(18'h00010);
    read_chk(18'h00010, 16'hA55A, "reset_keeps_mem");
    idle(18'h00010);
    chk("final_err", SIG_ERR, 16'h0);

    @(posedge clock);
    @(negedge clock);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
